// File: rtl/k2_pkg.sv
// Shared types and defaults for the k2 fetch sequencer.
// The HALT state exists only when K2_LOOP_HALT_EN is defined.
package k2_pkg;

    localparam int K2_PC_W     = 8;
    localparam int K2_RESET_PC = 0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        EXEC2 = 2'd2
`ifdef K2_LOOP_HALT_EN
        ,
        HALT  = 2'd3
`endif
    } k2_seq_state_t;

endpackage

// File: rtl/k2_fetch_sequencer.sv
// Fetch/execute sequencer: FETCH -> EXEC [-> EXEC2] -> FETCH.
// Define K2_LOOP_HALT_EN to stop in HALT on a self-jump.
module k2_fetch_sequencer
    import k2_pkg::*;
#(
    parameter int PC_W     = K2_PC_W,
    parameter int RESET_PC = K2_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            imem_valid,
    output logic            imem_ready,
    input  logic [7:0]      instr,
    input  logic            two_phase,
    input  logic            jcf,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic [7:0]      ir,
    output logic            s_reg,
    output logic            exec_valid,
    output logic            halted
);

    k2_seq_state_t   state, state_n;
    logic [PC_W-1:0] pc_n;
    logic [7:0]      ir_n;
    logic [PC_W-1:0] pc_inc;

    assign pc_inc = pc + PC_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= PC_W'(RESET_PC);
            ir    <= '0;
            s_reg <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
            // s_reg is registered so it tracks EXEC2 without decode glitches
            s_reg <= (state_n == EXEC2);
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        case (state)
            FETCH: begin
                if (imem_valid) begin
                    ir_n    = instr;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (two_phase) begin
                    state_n = EXEC2;
                end else if (jcf) begin
`ifdef K2_LOOP_HALT_EN
                    if (target == pc) begin
                        state_n = HALT;
                    end else begin
                        pc_n    = target;
                        state_n = FETCH;
                    end
`else
                    pc_n    = target;
                    state_n = FETCH;
`endif
                end else begin
                    pc_n    = pc_inc;
                    state_n = FETCH;
                end
            end
            EXEC2: begin
                pc_n    = pc_inc;
                state_n = FETCH;
            end
`ifdef K2_LOOP_HALT_EN
            HALT: state_n = HALT;
`endif
            default: state_n = FETCH;
        endcase
    end

    assign imem_ready = (state == FETCH);
    assign exec_valid = (state == EXEC) || (state == EXEC2);

`ifdef K2_LOOP_HALT_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: doc/k2_fetch_sequencer.md
K2_FETCH_SEQUENCER -- requirements
Module: k2_fetch_sequencer

Interface
REQ-001 Parameter PC_W, default 8, program-counter width in bits.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_valid  input  1  instruction memory presents a valid word on instr.
REQ-006 imem_ready  output  1  sequencer accepts instr this cycle; transfer occurs when imem_valid and imem_ready are both high.
REQ-007 instr  input  8  fetched instruction word.
REQ-008 two_phase  input  1  decoded flag: the current instruction needs a second execute phase (stores, jump-with-select).
REQ-009 jcf  input  1  jump-condition flag from the ALU condition logic, sampled in EXEC.
REQ-010 target  input  PC_W  jump destination, sampled in EXEC.
REQ-011 pc  output  PC_W  address driven to instruction memory.
REQ-012 ir  output  8  latched instruction register.
REQ-013 s_reg  output  1  phase bit fed back to the condition logic; 1 only in EXEC2.
REQ-014 exec_valid  output  1  ir holds an instruction in execution (EXEC or EXEC2).
REQ-015 halted  output  1  self-loop halt indicator (see REQ-030).

Function
REQ-016 FSM states: FETCH, EXEC, EXEC2, HALT; the encoding is a shared enum.
REQ-017 FETCH: imem_ready=1; on handshake, ir<=instr and next state is EXEC; without handshake, remain in FETCH with pc held.
REQ-018 imem_ready SHALL be 0 in every state other than FETCH.
REQ-019 EXEC with two_phase=0: if jcf=1 then pc<=target, else pc<=pc+1 (mod 2^PC_W); next state is FETCH.
REQ-020 EXEC with two_phase=1: pc unchanged; next state is EXEC2; jcf is ignored.
REQ-021 EXEC2: s_reg=1; pc<=pc+1 (mod 2^PC_W) regardless of jcf; next state is FETCH.
REQ-022 s_reg SHALL be a registered output, high exactly for the single cycle spent in EXEC2.
REQ-023 Fetch-to-next-fetch latency: single-phase instruction 2 cycles; two-phase instruction 3 cycles (with imem_valid held high).
REQ-024 pc wraps from 2^PC_W-1 to 0 on increment with no flag raised.
REQ-025 A jump to target equal to pc+1 SHALL behave identically to fall-through.
REQ-026 ir SHALL change only on a FETCH handshake.

Reset
REQ-027 While rst_n=0, regardless of clk: state=FETCH, pc=RESET_PC, ir=0, s_reg=0, exec_valid=0, halted=0, imem_ready=1.
REQ-028 Reset asserted mid-EXEC2 SHALL clear s_reg immediately; no pc increment SHALL occur on deassertion.
REQ-029 The first handshake after rst_n rises fetches from RESET_PC.

Configuration
REQ-030 Macro K2_LOOP_HALT_EN defined: in EXEC with two_phase=0, jcf=1 and target==pc, next state is HALT, halted=1, and the FSM stays there until reset; imem_ready=0 in HALT.
REQ-031 Macro K2_LOOP_HALT_EN undefined: the HALT state is absent, halted is tied to 0, and a self-jump re-fetches pc indefinitely.

Structure
REQ-032 Package k2_pkg SHALL hold the state enum type k2_seq_state_t, the PC_W default, and the RESET_PC default.
REQ-033 The block is flat; no sub-module is required.

Verification
REQ-034 Reset, then imem_valid=1, instr=8'h12, two_phase=0, jcf=0 -> pc sequence 0,0,1; s_reg stays 0.
REQ-035 At pc=5 in EXEC, jcf=1, target=8'h20 -> pc=8'h20 on the next cycle and imem_ready=1.
REQ-036 two_phase=1 at pc=3 -> EXEC2 follows with s_reg=1 for exactly one cycle, then pc=4; jcf=1 is ignored.
REQ-037 pc=8'hFF, single-phase, jcf=0 -> pc=8'h00.
REQ-038 imem_valid held 0 for 4 cycles in FETCH -> pc and ir unchanged, imem_ready=1 throughout.
REQ-039 With K2_LOOP_HALT_EN, jcf=1 and target==pc=7 -> halted=1 and imem_ready=0 until rst_n=0; without the macro, pc stays at 7 and fetching continues.
